spi_led_regs: RTL and testbench

SPI-side register block for the LED path. It decodes byte frames delivered by the SPI slave and holds per-LED brightness and enable registers. It drives the `i_d` and `i_enb` inputs of one `pwm` instance per LED. Writes are staged in shadow registers and committed atomically at frame end, so all LEDs change together. Each `pwm` then latches the new duty at its own period wrap.

---
 rtl/spi_led_regs_pkg.sv | 36 +++
 rtl/spi_led_regs_regfile.sv | 96 +++++++++
 rtl/spi_led_regs.sv | 179 +++++++++++++++++
 tb/tb_spi_led_regs.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_led_regs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_led_regs_pkg
// Purpose  : Shared constants, command field positions and FSM encoding for
//            the SPI LED register block.
// Revision : 1.0 - initial release
// ============================================================================
package spi_led_regs_pkg;

    localparam int BRIGHTNESS_WIDTH = 8;

    localparam logic [3:0] ADDR_BR0    = 4'h0;
    localparam logic [3:0] ADDR_ENB    = 4'h8;
    localparam logic [3:0] ADDR_STATUS = 4'h9;
    localparam logic [3:0] ADDR_ID     = 4'hF;

    localparam int CMD_W_BIT    = 7;
    localparam int CMD_RSVD_MSB = 6;
    localparam int CMD_RSVD_LSB = 4;
    localparam int CMD_ADDR_MSB = 3;
    localparam int CMD_ADDR_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_DATA  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Brightness registers occupy the bottom of the map, one per LED.
    function automatic logic is_br_addr(input logic [3:0] addr, input int n_leds);
        return addr < 4'(n_leds);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_led_regs_regfile.sv
`default_nettype none
// ============================================================================
// Module   : spi_led_regfile
// Purpose  : Shadow/live LED registers with write port, atomic commit and
//            combinational read mux over the live copy.
// Revision : 1.0 - initial release
// ============================================================================
module spi_led_regfile
    import spi_led_regs_pkg::*;
#(
    parameter int         N_LEDS   = 4,
    parameter int         BW       = BRIGHTNESS_WIDTH,
    parameter logic [7:0] ID_VALUE = 8'hA5
) (
    input  logic                   sysclk,
    input  logic                   i_rst_n,
    input  logic                   i_reload,
    input  logic                   i_commit,
    input  logic                   i_wr_en,
    input  logic [3:0]             i_wr_addr,
    input  logic [7:0]             i_wr_data,
    input  logic [3:0]             i_rd_addr,
    input  logic                   i_err,
    output logic [7:0]             o_rd_data,
    output logic [N_LEDS*BW-1:0]   o_brightness,
    output logic [N_LEDS-1:0]      o_enb
);

    logic [BW-1:0]     r_sh_br   [N_LEDS];
    logic [BW-1:0]     r_live_br [N_LEDS];
    logic [N_LEDS-1:0] r_sh_enb;
    logic [N_LEDS-1:0] r_live_enb;
    logic              w_unused_wr_bits;

    assign w_unused_wr_bits = ^i_wr_data;

    always_ff @(posedge sysclk) begin
        if (!i_rst_n) begin
            for (int k = 0; k < N_LEDS; k++) begin
                r_sh_br[k]   <= '0;
                r_live_br[k] <= '0;
            end
            r_sh_enb   <= '0;
            r_live_enb <= '0;
        end else begin
            if (i_commit) begin
                for (int k = 0; k < N_LEDS; k++) begin
                    r_live_br[k] <= r_sh_br[k];
                end
                r_live_enb <= r_sh_enb;
            end
            // A commit landing on a reload already leaves shadow equal to the new live values.
            if (i_reload && !i_commit) begin
                for (int k = 0; k < N_LEDS; k++) begin
                    r_sh_br[k] <= r_live_br[k];
                end
                r_sh_enb <= r_live_enb;
            end else if (i_wr_en) begin
                for (int k = 0; k < N_LEDS; k++) begin
                    if (i_wr_addr == ADDR_BR0 + 4'(k)) begin
                        r_sh_br[k] <= i_wr_data[BW-1:0];
                    end
                end
                if (i_wr_addr == ADDR_ENB) begin
                    r_sh_enb <= i_wr_data[N_LEDS-1:0];
                end
            end
        end
    end

    always_comb begin
        o_rd_data = 8'h00;
        case (i_rd_addr)
            ADDR_ENB:    o_rd_data = 8'(r_live_enb);
            ADDR_STATUS: o_rd_data = {7'b0, i_err};
            ADDR_ID:     o_rd_data = ID_VALUE;
            default: begin
                for (int k = 0; k < N_LEDS; k++) begin
                    if (i_rd_addr == ADDR_BR0 + 4'(k)) begin
                        o_rd_data = 8'(r_live_br[k]);
                    end
                end
            end
        endcase
    end

    generate
        for (genvar g = 0; g < N_LEDS; g++) begin : g_led_flat
            assign o_brightness[g*BW +: BW] = r_live_br[g];
        end
    endgenerate

    assign o_enb = r_live_enb;

endmodule
`default_nettype wire

// File: rtl/spi_led_regs.sv
`default_nettype none
// ============================================================================
// Module   : spi_led_regs
// Purpose  : SPI byte-frame decoder for per-LED brightness/enable registers
//            with frame-atomic commit and sticky protocol error.
// Revision : 1.0 - initial release
// ============================================================================
module spi_led_regs
    import spi_led_regs_pkg::*;
#(
    parameter int         N_LEDS   = 4,
    parameter int         BW       = BRIGHTNESS_WIDTH,
    parameter logic [7:0] ID_VALUE = 8'hA5
) (
    input  logic                   sysclk,
    input  logic                   i_rst_n,
    input  logic                   i_cs_n,
    input  logic                   i_rx_valid,
    input  logic [7:0]             i_rx_byte,
    output logic [7:0]             o_tx_byte,
    output logic [N_LEDS*BW-1:0]   o_brightness,
    output logic [N_LEDS-1:0]      o_enb,
    output logic                   o_err
);

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_cs_n_q;
    logic [3:0] r_addr;
    logic       r_wr;
    logic       r_frame_wr;
    logic       r_frame_err;
    logic       r_err;
    logic       r_commit;
    logic [7:0] r_tx;

    logic [3:0] w_cmd_addr;
    logic       w_cmd_w;
    logic       w_cmd_ok;
    logic [3:0] w_addr_inc;
    logic       w_cs_rise;
    logic       w_stray;
    logic       w_reload;
    logic       w_latch_cmd;
    logic       w_cmd_err;
    logic       w_wr_en;
    logic       w_load_tx;
    logic       w_adv_addr;
    logic       w_clr_err;
    logic [3:0] w_rd_addr;
    logic [7:0] w_rd_data;

    assign w_cmd_addr = i_rx_byte[CMD_ADDR_MSB:CMD_ADDR_LSB];
    assign w_cmd_w    = i_rx_byte[CMD_W_BIT];
    assign w_cmd_ok   = (i_rx_byte[CMD_RSVD_MSB:CMD_RSVD_LSB] == 3'b000)
                      && (is_br_addr(w_cmd_addr, N_LEDS) || (w_cmd_addr == ADDR_ENB)
                          || (!w_cmd_w && ((w_cmd_addr == ADDR_STATUS) || (w_cmd_addr == ADDR_ID))));

    assign w_addr_inc = !is_br_addr(r_addr, N_LEDS)     ? r_addr   :
                        (r_addr == 4'(N_LEDS - 1))      ? ADDR_BR0 :
                                                          r_addr + 4'd1;

    // r_cs_n_q resets low so a frame still open at reset release is drained, not decoded.
    assign w_cs_rise = i_cs_n & ~r_cs_n_q;
    assign w_stray   = i_rx_valid & i_cs_n & r_cs_n_q;

    always_comb begin
        w_state_nxt = r_state;
        w_reload    = 1'b0;
        w_latch_cmd = 1'b0;
        w_cmd_err   = 1'b0;
        w_wr_en     = 1'b0;
        w_load_tx   = 1'b0;
        w_adv_addr  = 1'b0;
        w_clr_err   = 1'b0;
        w_rd_addr   = r_addr;
        if (i_cs_n) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_cs_n_q) begin
                        w_state_nxt = ST_CMD;
                        w_reload    = 1'b1;
                    end else begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
                ST_CMD: begin
                    if (i_rx_valid) begin
                        if (w_cmd_ok) begin
                            w_state_nxt = ST_DATA;
                            w_latch_cmd = 1'b1;
                            w_load_tx   = 1'b1;
                            w_rd_addr   = w_cmd_addr;
                            w_clr_err   = !w_cmd_w && (w_cmd_addr == ADDR_STATUS);
                        end else begin
                            w_state_nxt = ST_DRAIN;
                            w_cmd_err   = 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (i_rx_valid) begin
                        w_adv_addr = 1'b1;
                        w_wr_en    = r_wr;
                        w_load_tx  = !r_wr;
                        w_rd_addr  = w_addr_inc;
                        w_clr_err  = !r_wr && (w_addr_inc == ADDR_STATUS);
                    end
                end
                default: w_state_nxt = ST_DRAIN;
            endcase
        end
    end

    always_ff @(posedge sysclk) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_cs_n_q    <= 1'b0;
            r_addr      <= '0;
            r_wr        <= 1'b0;
            r_frame_wr  <= 1'b0;
            r_frame_err <= 1'b0;
            r_err       <= 1'b0;
            r_commit    <= 1'b0;
            r_tx        <= 8'h00;
        end else begin
            r_state  <= w_state_nxt;
            r_cs_n_q <= i_cs_n;
            if (w_latch_cmd) begin
                r_addr <= w_cmd_addr;
                r_wr   <= w_cmd_w;
            end else if (w_adv_addr) begin
                r_addr <= w_addr_inc;
            end
            if (w_reload) begin
                r_frame_wr  <= 1'b0;
                r_frame_err <= 1'b0;
            end else begin
                if (w_wr_en)   r_frame_wr  <= 1'b1;
                if (w_cmd_err) r_frame_err <= 1'b1;
            end
            if (w_cmd_err || w_stray) begin
                r_err <= 1'b1;
            end else if (w_clr_err) begin
                r_err <= 1'b0;
            end
            if (w_load_tx) begin
                r_tx <= w_rd_data;
            end
            r_commit <= w_cs_rise & r_frame_wr & ~r_frame_err;
        end
    end

    spi_led_regfile #(
        .N_LEDS   (N_LEDS),
        .BW       (BW),
        .ID_VALUE (ID_VALUE)
    ) u_regfile (
        .sysclk       (sysclk),
        .i_rst_n      (i_rst_n),
        .i_reload     (w_reload),
        .i_commit     (r_commit),
        .i_wr_en      (w_wr_en),
        .i_wr_addr    (r_addr),
        .i_wr_data    (i_rx_byte),
        .i_rd_addr    (w_rd_addr),
        .i_err        (r_err),
        .o_rd_data    (w_rd_data),
        .o_brightness (o_brightness),
        .o_enb        (o_enb)
    );

    assign o_tx_byte = r_tx;
    assign o_err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_led_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_led_regs
// Purpose  : Self-checking bench: directed frame table, random frames against
//            a frame-level reference model, and hand-written corner sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_led_regs;

    localparam int NL  = 4;
    localparam int BWT = 8;

    logic             sysclk = 1'b0;
    logic             rst_n;
    logic             cs_n;
    logic             rx_valid;
    logic [7:0]       rx_byte;
    logic [7:0]       tx_byte;
    logic [NL*BWT-1:0] brightness;
    logic [NL-1:0]    enb;
    logic             err;

    always #5 sysclk = ~sysclk;

    spi_led_regs #(.N_LEDS(NL), .BW(BWT), .ID_VALUE(8'hA5)) dut (
        .sysclk       (sysclk),
        .i_rst_n      (rst_n),
        .i_cs_n       (cs_n),
        .i_rx_valid   (rx_valid),
        .i_rx_byte    (rx_byte),
        .o_tx_byte    (tx_byte),
        .o_brightness (brightness),
        .o_enb        (enb),
        .o_err        (err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Frame-level reference model
    int          m_br [NL];
    int          m_enb;
    int          m_err;
    int          m_tx;
    logic [31:0] old_br;
    int          old_enb;
    logic [7:0]  g_frame [$];
    int          g_exp_tx [$];

    function automatic int rd(input int a);
        if (a < NL)  return m_br[a];
        if (a == 8)  return m_enb;
        if (a == 9)  return m_err;
        if (a == 15) return 8'hA5;
        return 0;
    endfunction

    function automatic logic [31:0] pack_br();
        logic [31:0] p = '0;
        for (int k = 0; k < NL; k++) p[k*BWT +: BWT] = BWT'(m_br[k]);
        return p;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NL; k++) m_br[k] = 0;
        m_enb = 0; m_err = 0; m_tx = 0;
    endtask

    task automatic model_frame();
        int sh_br [NL];
        int sh_enb, a, cmd;
        bit w, ok, wrote;
        g_exp_tx.delete();
        old_br  = pack_br();
        old_enb = m_enb;
        for (int k = 0; k < NL; k++) sh_br[k] = m_br[k];
        sh_enb = m_enb;
        wrote  = 0;
        cmd = int'(g_frame[0]);
        a   = cmd % 16;
        w   = (cmd >= 128);
        ok  = (((cmd / 16) % 8) == 0) && (a < NL || a == 8 || (!w && (a == 9 || a == 15)));
        if (!ok) begin
            m_err = 1;
            foreach (g_frame[i]) g_exp_tx.push_back(m_tx);
            return;
        end
        m_tx = rd(a);
        if (!w && a == 9) m_err = 0;
        g_exp_tx.push_back(m_tx);
        for (int i = 1; i < g_frame.size(); i++) begin
            if (w) begin
                if (a < NL) sh_br[a] = int'(g_frame[i]) % (1 << BWT);
                else        sh_enb   = int'(g_frame[i]) % (1 << NL);
                wrote = 1;
            end
            if (a < NL) a = (a + 1) % NL;
            if (!w) begin
                m_tx = rd(a);
                if (a == 9) m_err = 0;
            end
            g_exp_tx.push_back(m_tx);
        end
        if (wrote) begin
            for (int k = 0; k < NL; k++) m_br[k] = sh_br[k];
            m_enb = sh_enb;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge sysclk);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(negedge sysclk);
        rx_valid = 1'b0;
    endtask

    task automatic run_frame(input string tag);
        model_frame();
        @(negedge sysclk);
        cs_n = 1'b0;
        for (int i = 0; i < g_frame.size(); i++) begin
            send_byte(g_frame[i]);
            chk($sformatf("%s tx[%0d]", tag, i), 32'(tx_byte), 32'(g_exp_tx[i]));
        end
        chk({tag, " br_cs_low"}, brightness, old_br);
        cs_n = 1'b1;
        @(negedge sysclk);
        chk({tag, " br_hold"}, brightness, old_br);
        chk({tag, " enb_hold"}, 32'(enb), 32'(old_enb));
        @(negedge sysclk);
        chk({tag, " br_commit"}, brightness, pack_br());
        chk({tag, " enb_commit"}, 32'(enb), 32'(m_enb));
        chk({tag, " err"}, 32'(err), 32'(m_err));
    endtask

    typedef struct {
        int          len;
        logic [7:0]  b [4];
        logic [31:0] br;
        logic [3:0]  enb;
        logic        er;
        logic [7:0]  tx;
    } vec_t;

    vec_t tbl [$];

    task automatic add_vec(input int len, input logic [7:0] b0, b1, b2, b3,
                           input logic [31:0] br, input logic [3:0] en,
                           input logic er, input logic [7:0] tx);
        vec_t v;
        v.len = len;
        v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3;
        v.br = br; v.enb = en; v.er = er; v.tx = tx;
        tbl.push_back(v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] seq [5];
        int len, pick, a, rsv;
        bit w;

        rst_n = 1'b0; cs_n = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00;
        model_reset();
        repeat (3) @(negedge sysclk);
        rst_n = 1'b1;
        @(negedge sysclk);
        chk("reset br", brightness, 32'h0);
        chk("reset enb", 32'(enb), 32'h0);
        chk("reset err", 32'(err), 32'h0);
        chk("reset tx", 32'(tx_byte), 32'h0);

        add_vec(1, 8'h0F, 0, 0, 0, 32'h0000_0000, 4'h0, 1'b0, 8'hA5);
        add_vec(2, 8'h80, 8'h40, 0, 0, 32'h0000_0040, 4'h0, 1'b0, 8'h00);
        add_vec(4, 8'h82, 8'h11, 8'h22, 8'h33, 32'h2211_0033, 4'h0, 1'b0, 8'h00);
        add_vec(4, 8'hC5, 8'h80, 8'h10, 8'h99, 32'h2211_0033, 4'h0, 1'b1, 8'h00);
        add_vec(1, 8'h09, 0, 0, 0, 32'h2211_0033, 4'h0, 1'b0, 8'h01);
        add_vec(2, 8'h88, 8'h0F, 0, 0, 32'h2211_0033, 4'hF, 1'b0, 8'h00);
        add_vec(1, 8'h08, 0, 0, 0, 32'h2211_0033, 4'hF, 1'b0, 8'h0F);
        add_vec(2, 8'h03, 8'h00, 0, 0, 32'h2211_0033, 4'hF, 1'b0, 8'h33);
        add_vec(2, 8'h8F, 8'h12, 0, 0, 32'h2211_0033, 4'hF, 1'b1, 8'h33);
        add_vec(2, 8'h09, 8'h00, 0, 0, 32'h2211_0033, 4'hF, 1'b0, 8'h00);
        add_vec(1, 8'h05, 0, 0, 0, 32'h2211_0033, 4'hF, 1'b1, 8'h00);
        add_vec(2, 8'h89, 8'h00, 0, 0, 32'h2211_0033, 4'hF, 1'b1, 8'h00);
        add_vec(1, 8'h09, 0, 0, 0, 32'h2211_0033, 4'hF, 1'b0, 8'h01);
        add_vec(3, 8'h81, 8'hAB, 8'hCD, 0, 32'h22CD_AB33, 4'hF, 1'b0, 8'h00);

        foreach (tbl[t]) begin
            g_frame.delete();
            for (int i = 0; i < tbl[t].len; i++) g_frame.push_back(tbl[t].b[i]);
            run_frame($sformatf("vec%0d", t));
            chk($sformatf("vec%0d br", t), brightness, tbl[t].br);
            chk($sformatf("vec%0d enb", t), 32'(enb), 32'(tbl[t].enb));
            chk($sformatf("vec%0d err", t), 32'(err), 32'(tbl[t].er));
            chk($sformatf("vec%0d tx", t), 32'(tx_byte), 32'(tbl[t].tx));
        end

        for (int r = 0; r < 40; r++) begin
            len  = $urandom_range(1, 5);
            pick = $urandom_range(0, 9);
            if (pick < 5)       a = $urandom_range(0, NL - 1);
            else if (pick == 5) a = 8;
            else if (pick == 6) a = 9;
            else if (pick == 7) a = 15;
            else                a = $urandom_range(0, 15);
            w   = 1'($urandom_range(0, 1));
            rsv = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 7) : 0;
            seq[0] = {w, 3'(rsv), 4'(a)};
            for (int i = 1; i < 5; i++) seq[i] = 8'($urandom_range(0, 255));
            g_frame.delete();
            for (int i = 0; i < len; i++) g_frame.push_back(seq[i]);
            run_frame($sformatf("rnd%0d", r));
        end

        // Stray strobe while deselected sets the sticky error.
        send_byte(8'h42);
        m_err = 1;
        chk("stray err", 32'(err), 32'h1);
        g_frame.delete(); g_frame.push_back(8'h09);
        run_frame("stray status");
        chk("stray cleared", 32'(err), 32'h0);

        // Byte strobe coinciding with the CS rise is discarded without error.
        g_frame.delete(); g_frame.push_back(8'h80); g_frame.push_back(8'h5A);
        model_frame();
        @(negedge sysclk); cs_n = 1'b0;
        send_byte(8'h80);
        send_byte(8'h5A);
        cs_n = 1'b1; rx_valid = 1'b1; rx_byte = 8'h99;
        @(negedge sysclk); rx_valid = 1'b0;
        @(negedge sysclk);
        chk("rise strobe err", 32'(err), 32'h0);
        chk("rise strobe commit", brightness, pack_br());
        chk("rise strobe led0", 32'(brightness[7:0]), 32'h5A);

        // Back-to-back strobes, every one processed.
        g_frame.delete();
        g_frame.push_back(8'h80); g_frame.push_back(8'h01); g_frame.push_back(8'h02);
        g_frame.push_back(8'h03); g_frame.push_back(8'h04);
        model_frame();
        @(negedge sysclk); cs_n = 1'b0;
        @(negedge sysclk);
        rx_valid = 1'b1;
        foreach (g_frame[i]) begin
            rx_byte = g_frame[i];
            @(negedge sysclk);
        end
        rx_valid = 1'b0; cs_n = 1'b1;
        repeat (2) @(negedge sysclk);
        chk("b2b br", brightness, 32'h0403_0201);
        chk("b2b model", brightness, pack_br());

        // Reset in the middle of a write frame, frame remainder drained.
        @(negedge sysclk); cs_n = 1'b0;
        send_byte(8'h81);
        send_byte(8'h55);
        rst_n = 1'b0;
        repeat (2) @(negedge sysclk);
        rst_n = 1'b1;
        model_reset();
        @(negedge sysclk);
        chk("midrst br", brightness, 32'h0);
        chk("midrst tx", 32'(tx_byte), 32'h0);
        send_byte(8'h82);
        send_byte(8'h77);
        chk("midrst drain tx", 32'(tx_byte), 32'h0);
        cs_n = 1'b1;
        repeat (3) @(negedge sysclk);
        chk("midrst after br", brightness, 32'h0);
        chk("midrst after err", 32'(err), 32'h0);
        g_frame.delete(); g_frame.push_back(8'h81); g_frame.push_back(8'h66);
        run_frame("post rst");
        chk("post rst led1", brightness, 32'h0000_6600);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
